// File: rtl/pcie_rx_pkg.sv
// Shared types and constants for the PCIe 8b/10b receive chain.
package pcie_rx_pkg;

    localparam int unsigned SYM_W = 10;

    localparam logic [SYM_W-1:0] K28_5_RDN = 10'h17C;
    localparam logic [SYM_W-1:0] K28_5_RDP = 10'h283;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        ACQ    = 2'd1,
        LOCKED = 2'd2
    } align_state_t;

    // True when a 10-bit window holds K28.5 of either running disparity.
    function automatic logic is_k28_5(input logic [SYM_W-1:0] s);
        return (s == K28_5_RDN) || (s == K28_5_RDP);
    endfunction

endpackage

// File: rtl/sipo_align_ctrl_if.sv
// Serial-in / aligned-symbol-out bundle between the bit source, the aligner and the decoder.
interface sipo_align_ctrl_if;
    import pcie_rx_pkg::*;

    logic             sin;
    logic             sin_en;
    logic [SYM_W-1:0] sym;
    logic             sym_valid;
    logic             sym_is_comma;
    logic             locked;
    logic             realign;

    modport master (
        output sin, sin_en,
        input  sym, sym_valid, sym_is_comma, locked, realign
    );

    modport slave (
        input  sin, sin_en,
        output sym, sym_valid, sym_is_comma, locked, realign
    );

endinterface

// File: rtl/sipo_align_ctrl_shift10.sv
// sipo_shift10: 10-bit LSB-first deserialising window; the first bit of a symbol ends up in [0].
module sipo_shift10
    import pcie_rx_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             sin_i,
    input  logic             sin_en_i,
    output logic [SYM_W-1:0] win_nxt_o
);

    logic [SYM_W-1:0] win_q;

    assign win_nxt_o = {sin_i, win_q[SYM_W-1:1]};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            win_q <= '0;
        end else if (sin_en_i) begin
            win_q <= win_nxt_o;
        end
    end

endmodule

// File: rtl/sipo_align_ctrl.sv
// K28.5 symbol-alignment controller: hunts for the comma, emits aligned symbols, tracks lock.
// Build option SIPO_ALIGN_REALIGN_EN: a misaligned comma while locked re-establishes the boundary.
module sipo_align_ctrl
    import pcie_rx_pkg::*;
#(
    parameter int unsigned ACQ_COMMAS = 3,
    parameter int unsigned MAX_GAP    = 1024
) (
    input  logic               clk,
    input  logic               rst,
    sipo_align_ctrl_if.slave   bus
);

    localparam int unsigned GAP_W = $clog2(MAX_GAP + 1);
    localparam int unsigned CNT_W = $clog2(ACQ_COMMAS + 1);
    localparam int unsigned BIT_W = 4;

    align_state_t     state_q,        state_d;
    logic [BIT_W-1:0] bit_cnt_q,      bit_cnt_d;
    logic [CNT_W-1:0] comma_cnt_q,    comma_cnt_d;
    logic [GAP_W-1:0] gap_q,          gap_d;
    logic [SYM_W-1:0] sym_q,          sym_d;
    logic             sym_valid_q,    sym_valid_d;
    logic             sym_is_comma_q, sym_is_comma_d;
    logic             locked_q,       locked_d;
    logic             realign_q,      realign_d;

    logic [SYM_W-1:0] win_nxt;
    logic             match_c;
    logic             boundary_c;
    logic             do_realign_c;

    sipo_shift10 u_shift (
        .clk       (clk),
        .rst       (rst),
        .sin_i     (bus.sin),
        .sin_en_i  (bus.sin_en),
        .win_nxt_o (win_nxt)
    );

    assign match_c    = bus.sin_en && is_k28_5(win_nxt);
    assign boundary_c = (bit_cnt_q == BIT_W'(SYM_W - 1));

    // Next-state, counter and output decode; everything holds while sin_en is low.
    always_comb begin
        state_d        = state_q;
        bit_cnt_d      = bit_cnt_q;
        comma_cnt_d    = comma_cnt_q;
        gap_d          = gap_q;
        sym_d          = sym_q;
        sym_valid_d    = 1'b0;
        sym_is_comma_d = 1'b0;
        realign_d      = 1'b0;
        do_realign_c   = 1'b0;

        if (bus.sin_en) begin
            bit_cnt_d = boundary_c ? '0 : bit_cnt_q + BIT_W'(1);

            unique case (state_q)
                HUNT: begin
                    do_realign_c = match_c;
                end
                ACQ, LOCKED: begin
                    if (state_q == ACQ && match_c && !boundary_c) begin
                        do_realign_c = 1'b1;
                    end
`ifdef SIPO_ALIGN_REALIGN_EN
                    if (state_q == LOCKED && match_c && !boundary_c) begin
                        do_realign_c = 1'b1;
                    end
`endif
                    if (boundary_c) begin
                        sym_d          = win_nxt;
                        sym_valid_d    = 1'b1;
                        sym_is_comma_d = match_c;
                        if (match_c) begin
                            // An aligned comma clears the gap even on the edge it would expire.
                            gap_d = '0;
                            if (state_q == ACQ) begin
                                comma_cnt_d = comma_cnt_q + CNT_W'(1);
                                if (comma_cnt_q == CNT_W'(ACQ_COMMAS - 1)) begin
                                    state_d = LOCKED;
                                end
                            end
                        end else if (gap_q == GAP_W'(MAX_GAP - 1)) begin
                            gap_d   = '0;
                            state_d = HUNT;
                        end else begin
                            gap_d = gap_q + GAP_W'(1);
                        end
                    end
                end
                default: begin
                    state_d = HUNT;
                end
            endcase

            if (do_realign_c) begin
                sym_d          = win_nxt;
                sym_valid_d    = 1'b1;
                sym_is_comma_d = 1'b1;
                realign_d      = 1'b1;
                bit_cnt_d      = '0;
                comma_cnt_d    = CNT_W'(1);
                gap_d          = '0;
                state_d        = (ACQ_COMMAS == 1) ? LOCKED : ACQ;
            end
        end

        locked_d = (state_d == LOCKED);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= HUNT;
            bit_cnt_q      <= '0;
            comma_cnt_q    <= '0;
            gap_q          <= '0;
            sym_q          <= '0;
            sym_valid_q    <= 1'b0;
            sym_is_comma_q <= 1'b0;
            locked_q       <= 1'b0;
            realign_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            bit_cnt_q      <= bit_cnt_d;
            comma_cnt_q    <= comma_cnt_d;
            gap_q          <= gap_d;
            sym_q          <= sym_d;
            sym_valid_q    <= sym_valid_d;
            sym_is_comma_q <= sym_is_comma_d;
            locked_q       <= locked_d;
            realign_q      <= realign_d;
        end
    end

    assign bus.sym          = sym_q;
    assign bus.sym_valid    = sym_valid_q;
    assign bus.sym_is_comma = sym_is_comma_q;
    assign bus.locked       = locked_q;
    assign bus.realign      = realign_q;

endmodule

// File: tb/tb_sipo_align_ctrl.sv
// Directed bench for sipo_align_ctrl (MAX_GAP=16 build); honours SIPO_ALIGN_REALIGN_EN if defined.
module tb_sipo_align_ctrl;
    import pcie_rx_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    sipo_align_ctrl_if bus ();

    sipo_align_ctrl #(.ACQ_COMMAS(3), .MAX_GAP(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [9:0] sym;
        logic       cm;
        logic       lk;
        logic       ra;
        int         t;
    } ev_t;

    ev_t evq[$];
    int  tcount   = 0;
    int  checks   = 0;
    int  failures = 0;
    int  t0;

    localparam logic [9:0] D21_5 = 10'h155;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One bit time: drive, let the edge pass, then record any emitted symbol.
    task automatic step(input logic b, input logic en);
        ev_t e;
        bus.sin    = b;
        bus.sin_en = en;
        @(posedge clk);
        #1;
        tcount++;
        if (bus.sym_valid === 1'b1) begin
            e.sym = bus.sym;
            e.cm  = bus.sym_is_comma;
            e.lk  = bus.locked;
            e.ra  = bus.realign;
            e.t   = tcount;
            evq.push_back(e);
        end
    endtask

    task automatic send_sym(input logic [9:0] s);
        for (int i = 0; i < 10; i++) step(s[i], 1'b1);
    endtask

    task automatic check_ev(input string tag, input int idx, input logic [9:0] sym,
                            input logic cm, input logic lk, input logic ra);
        if (idx < evq.size()) begin
            check({tag, "_sym"},   32'(evq[idx].sym), 32'(sym));
            check({tag, "_comma"}, 32'(evq[idx].cm),  32'(cm));
            check({tag, "_lock"},  32'(evq[idx].lk),  32'(lk));
            check({tag, "_ra"},    32'(evq[idx].ra),  32'(ra));
        end else begin
            check({tag, "_present"}, 32'(evq.size()), 32'(idx + 1));
        end
    endtask

    task automatic do_reset();
        rst        = 1'b0;
        bus.sin    = 1'b0;
        bus.sin_en = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        evq.delete();
    endtask

    task automatic lock_seq();
        do_reset();
        send_sym(10'h000);
        send_sym(10'h000);
        send_sym(K28_5_RDN);
        send_sym(K28_5_RDP);
        send_sym(K28_5_RDN);
    endtask

    initial begin
        logic prev;
        int   run;
        logic b;

        // Reset values with inputs active.
        bus.sin    = 1'b1;
        bus.sin_en = 1'b1;
        @(posedge clk);
        #1;
        check("rst_sym",     32'(bus.sym),          32'h0);
        check("rst_valid",   32'(bus.sym_valid),    32'h0);
        check("rst_comma",   32'(bus.sym_is_comma), 32'h0);
        check("rst_locked",  32'(bus.locked),       32'h0);
        check("rst_realign", 32'(bus.realign),      32'h0);

        // Test 1: idle then three back-to-back commas.
        do_reset();
        send_sym(10'h000);
        send_sym(10'h000);
        t0 = tcount;
        send_sym(K28_5_RDN);
        send_sym(K28_5_RDP);
        send_sym(K28_5_RDN);
        check("t1_count", 32'(evq.size()), 32'd3);
        check_ev("t1_e0", 0, 10'h17C, 1'b1, 1'b0, 1'b1);
        check_ev("t1_e1", 1, 10'h283, 1'b1, 1'b0, 1'b0);
        check_ev("t1_e2", 2, 10'h17C, 1'b1, 1'b1, 1'b0);
        if (evq.size() == 3) begin
            check("t1_t0",  32'(evq[0].t - t0),       32'd10);
            check("t1_gap", 32'(evq[2].t - evq[1].t), 32'd10);
        end
        step(1'b1, 1'b0);
        check("t1_hold_valid", 32'(bus.sym_valid), 32'h0);
        check("t1_hold_sym",   32'(bus.sym),       32'h17C);
        check("t1_hold_lock",  32'(bus.locked),    32'h1);

        // Test 2: comma-free random bits (runs capped at 4) never produce a symbol.
        do_reset();
        prev = 1'b0;
        run  = 0;
        for (int i = 0; i < 500; i++) begin
            b = 1'($urandom_range(0, 1));
            if (run >= 4 && b == prev) b = ~prev;
            run  = (b == prev) ? run + 1 : 1;
            prev = b;
            step(b, 1'b1);
        end
        check("t2_count",  32'(evq.size()),  32'd0);
        check("t2_locked", 32'(bus.locked),  32'h0);

        // Test 3: gap expiry, with an aligned comma rescuing the lock on the expiry edge.
        lock_seq();
        evq.delete();
        for (int i = 0; i < 15; i++) send_sym(D21_5);
        check("t3_lock15", 32'(bus.locked), 32'h1);
        send_sym(K28_5_RDN);
        for (int i = 0; i < 16; i++) send_sym(D21_5);
        for (int i = 0; i < 3; i++) send_sym(D21_5);
        check("t3_count", 32'(evq.size()), 32'd32);
        check_ev("t3_e0",  0,  D21_5,   1'b0, 1'b1, 1'b0);
        check_ev("t3_e14", 14, D21_5,   1'b0, 1'b1, 1'b0);
        check_ev("t3_e15", 15, 10'h17C, 1'b1, 1'b1, 1'b0);
        check_ev("t3_e30", 30, D21_5,   1'b0, 1'b1, 1'b0);
        check_ev("t3_e31", 31, D21_5,   1'b0, 1'b0, 1'b0);
        check("t3_locked", 32'(bus.locked), 32'h0);

        // Test 4: comma shifted by 3 bits while locked.
        lock_seq();
        evq.delete();
        step(1'b0, 1'b1);
        step(1'b1, 1'b1);
        step(1'b0, 1'b1);
        send_sym(K28_5_RDN);
        check_ev("t4_e0", 0, 10'h3E2, 1'b0, 1'b1, 1'b0);
`ifdef SIPO_ALIGN_REALIGN_EN
        check_ev("t4_e1", 1, 10'h17C, 1'b1, 1'b0, 1'b1);
        check("t4_locked", 32'(bus.locked), 32'h0);
        send_sym(K28_5_RDP);
        send_sym(K28_5_RDN);
        check_ev("t4_e2", 2, 10'h283, 1'b1, 1'b0, 1'b0);
        check_ev("t4_e3", 3, 10'h17C, 1'b1, 1'b1, 1'b0);
        check("t4_count", 32'(evq.size()), 32'd4);
`else
        check("t4_locked", 32'(bus.locked), 32'h1);
        for (int i = 0; i < 7; i++) step(1'(i % 2), 1'b1);
        check_ev("t4_e1", 1, 10'h152, 1'b0, 1'b1, 1'b0);
        send_sym(K28_5_RDN);
        check_ev("t4_e2", 2, 10'h17C, 1'b1, 1'b1, 1'b0);
        check("t4_count", 32'(evq.size()), 32'd3);
`endif

        // Test 5: sin_en toggling stretches the symbol spacing to 20 cycles.
        do_reset();
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 1'b1);
            step(1'b1, 1'b0);
        end
        t0 = tcount;
        for (int k = 0; k < 3; k++) begin
            logic [9:0] s;
            s = (k == 1) ? K28_5_RDP : K28_5_RDN;
            for (int i = 0; i < 10; i++) begin
                step(s[i], 1'b1);
                step(1'($urandom_range(0, 1)), 1'b0);
            end
        end
        check("t5_count", 32'(evq.size()), 32'd3);
        check_ev("t5_e0", 0, 10'h17C, 1'b1, 1'b0, 1'b1);
        check_ev("t5_e1", 1, 10'h283, 1'b1, 1'b0, 1'b0);
        check_ev("t5_e2", 2, 10'h17C, 1'b1, 1'b1, 1'b0);
        if (evq.size() == 3) begin
            check("t5_t0",   32'(evq[0].t - t0),       32'd19);
            check("t5_gap0", 32'(evq[1].t - evq[0].t), 32'd20);
            check("t5_gap1", 32'(evq[2].t - evq[1].t), 32'd20);
        end

        // Test 6: asynchronous reset in the middle of a symbol while locked.
        lock_seq();
        evq.delete();
        for (int i = 0; i < 5; i++) step(D21_5[i], 1'b1);
        rst = 1'b0;
        #1;
        check("t6_sym",     32'(bus.sym),          32'h0);
        check("t6_valid",   32'(bus.sym_valid),    32'h0);
        check("t6_comma",   32'(bus.sym_is_comma), 32'h0);
        check("t6_locked",  32'(bus.locked),       32'h0);
        check("t6_realign", 32'(bus.realign),      32'h0);
        bus.sin_en = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        step(1'b1, 1'b1);
        check("t6_first_valid", 32'(bus.sym_valid), 32'h0);
        for (int i = 0; i < 9; i++) step(1'(i % 2), 1'b1);
        send_sym(D21_5);
        send_sym(K28_5_RDN);
        check("t6_count", 32'(evq.size()), 32'd1);
        check_ev("t6_e0", 0, 10'h17C, 1'b1, 1'b0, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
